// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 encrypt path.
package arc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    IDLE,
    LEN_RD,
    LEN_CAP,
    SI_RD,
    SI_CAP,
    SJ_CAP,
    SJ_WR,
    PAD_RD,
    PAD_CAP,
    DONE
  } enc_state_t;

  localparam int LEN_ADDR        = 0;
  localparam int CYCLES_PER_BYTE = 6;

endpackage

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: length-prefixed PT memory -> length-prefixed CT memory using a pre-scheduled S.
// Optional running XOR of CT writes on port chk when ARC4_ENC_CHECKSUM_EN is defined.
module arc4_encrypt
  import arc4_pkg::*;
#(
  parameter int MSG_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  rdy,
  output logic [7:0]            s_addr,
  input  logic [7:0]            s_rddata,
  output logic [7:0]            s_wrdata,
  output logic                  s_wren,
  output logic [MSG_ADDR_W-1:0] pt_addr,
  input  logic [7:0]            pt_rddata,
  output logic [MSG_ADDR_W-1:0] ct_addr,
  output logic [7:0]            ct_wrdata,
  output logic                  ct_wren
`ifdef ARC4_ENC_CHECKSUM_EN
  ,
  output logic [7:0]            chk
`endif
);

  enc_state_t state, state_nxt;
  byte_t i, j, k, len, si, sj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      len   <= '0;
      si    <= '0;
      sj    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (en) begin
          i <= '0;
          j <= '0;
          k <= 8'd1;
        end
        LEN_CAP: len <= pt_rddata;
        SI_RD:   i <= i + 8'd1;
        SI_CAP: begin
          si <= s_rddata;
          j  <= j + s_rddata;
        end
        SJ_CAP:  sj <= s_rddata;
        PAD_CAP: if (k != len) k <= k + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    pt_addr   = '0;
    ct_addr   = '0;
    ct_wrdata = '0;
    ct_wren   = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) state_nxt = LEN_RD;
      end
      LEN_RD: begin
        pt_addr   = MSG_ADDR_W'(LEN_ADDR);
        state_nxt = LEN_CAP;
      end
      LEN_CAP: begin
        // Decide on the incoming byte; len only lands at this edge.
        ct_addr   = MSG_ADDR_W'(LEN_ADDR);
        ct_wrdata = pt_rddata;
        ct_wren   = 1'b1;
        state_nxt = (pt_rddata == 8'd0) ? DONE : SI_RD;
      end
      SI_RD: begin
        s_addr    = i + 8'd1;
        state_nxt = SI_CAP;
      end
      SI_CAP: begin
        s_addr    = j + s_rddata;
        state_nxt = SJ_CAP;
      end
      SJ_CAP: begin
        s_addr    = i;
        s_wrdata  = s_rddata;
        s_wren    = 1'b1;
        state_nxt = SJ_WR;
      end
      SJ_WR: begin
        s_addr    = j;
        s_wrdata  = si;
        s_wren    = 1'b1;
        state_nxt = PAD_RD;
      end
      PAD_RD: begin
        s_addr    = si + sj;
        pt_addr   = MSG_ADDR_W'(k);
        state_nxt = PAD_CAP;
      end
      PAD_CAP: begin
        ct_addr   = MSG_ADDR_W'(k);
        ct_wrdata = s_rddata ^ pt_rddata;
        ct_wren   = 1'b1;
        state_nxt = (k == len) ? DONE : SI_RD;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ARC4_ENC_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  chk <= '0;
    else if (state == IDLE && en) chk <= '0;
    else if (ct_wren)            chk <= chk ^ ct_wrdata;
  end
`endif

endmodule

// File: tb/tb_arc4_encrypt.sv
// Self-checking bench for arc4_encrypt against a byte-level RC4 reference model.
// Covers the checksum port as well when ARC4_ENC_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_arc4_encrypt;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] pt_addr, pt_rddata, ct_addr, ct_wrdata;
  logic       ct_wren;
`ifdef ARC4_ENC_CHECKSUM_EN
  logic [7:0] chk;
`endif

  always #5 clk = ~clk;

  arc4_encrypt #(.MSG_ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
`ifdef ARC4_ENC_CHECKSUM_EN
    , .chk(chk)
`endif
  );

  // Memories and write monitors
  logic [7:0] s_mem[256], ct_mem[256], pt_mem[256], s_init[256];
  logic       load_req = 1'b0;
  int         s_wr_cnt, ct_wr_cnt, excl_viol;

  always @(posedge clk) begin
    if (load_req) begin
      for (int n = 0; n < 256; n++) begin
        s_mem[n]  <= s_init[n];
        ct_mem[n] <= 8'hEE;
      end
      s_wr_cnt  <= 0;
      ct_wr_cnt <= 0;
      excl_viol <= 0;
    end else begin
      s_rddata  <= s_mem[s_addr];
      pt_rddata <= pt_mem[pt_addr];
      if (s_wren) begin
        s_mem[s_addr] <= s_wrdata;
        s_wr_cnt <= s_wr_cnt + 1;
      end
      if (ct_wren) begin
        ct_mem[ct_addr] <= ct_wrdata;
        ct_wr_cnt <= ct_wr_cnt + 1;
      end
      if (s_wren && ct_wren) excl_viol <= excl_viol + 1;
    end
  end

  int n_checks = 0, n_pass = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: plain RC4 over byte arrays
  logic [7:0] m_s[256], m_in[256], m_out[256];

  task automatic model_identity();
    for (int n = 0; n < 256; n++) m_s[n] = 8'(n);
  endtask

  task automatic model_shuffle();
    logic [7:0] tmp;
    int r;
    model_identity();
    for (int n = 255; n > 0; n--) begin
      r = $urandom_range(0, n);
      tmp = m_s[n]; m_s[n] = m_s[r]; m_s[r] = tmp;
    end
  endtask

  task automatic model_ksa(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
    logic [7:0] key[3];
    logic [7:0] jj, tmp;
    key[0] = k0; key[1] = k1; key[2] = k2;
    model_identity();
    jj = 8'd0;
    for (int n = 0; n < 256; n++) begin
      jj = jj + m_s[n] + key[n % 3];
      tmp = m_s[n]; m_s[n] = m_s[jj]; m_s[jj] = tmp;
    end
  endtask

  task automatic model_prga(input int len);
    logic [7:0] ii, jj, tt, tmp;
    ii = 8'd0; jj = 8'd0;
    for (int n = 1; n <= len; n++) begin
      ii = ii + 8'd1;
      jj = jj + m_s[ii];
      tmp = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = tmp;
      tt = m_s[ii] + m_s[jj];
      m_out[n] = m_in[n] ^ m_s[tt];
    end
  endtask

  task automatic load_mems();
    for (int n = 0; n < 256; n++) s_init[n] = m_s[n];
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic fill_pt(input int len);
    pt_mem[0] = 8'(len);
    for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom_range(0, 255));
  endtask

  task automatic run_enc(input bit pulse, output int cycles);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    cycles = 0;
    while (cycles < 3000) begin
      @(posedge clk);
      #1 cycles++;
      if (rdy) break;
      if (pulse) en = 1'($urandom_range(0, 1));
    end
    en = 1'b0;
  endtask

  // m_s must hold the S image that was loaded; compares CT and final S with the model.
  task automatic check_vs_model(input string tag, input int len);
    int bad_ct, bad_s;
    logic [7:0] x;
    for (int n = 0; n < 256; n++) m_in[n] = pt_mem[n];
    model_prga(len);
    bad_ct = 0; bad_s = 0;
    x = 8'(len);
    for (int n = 1; n <= len; n++) begin
      if (ct_mem[n] !== m_out[n]) bad_ct++;
      x = x ^ m_out[n];
    end
    for (int n = 0; n < 256; n++) if (s_mem[n] !== m_s[n]) bad_s++;
    check_eq({tag, "_ct0"}, int'(ct_mem[0]), len);
    check_eq({tag, "_ct_bytes_bad"}, bad_ct, 0);
    check_eq({tag, "_s_final_bad"}, bad_s, 0);
    check_eq({tag, "_ct_writes"}, ct_wr_cnt, len + 1);
    check_eq({tag, "_s_writes"}, s_wr_cnt, 2 * len);
`ifdef ARC4_ENC_CHECKSUM_EN
    check_eq({tag, "_chk"}, int'(chk), int'(x));
`endif
  endtask

  initial begin
    int cyc, len;
    // Reset state
    #12;
    check_eq("rst_rdy", int'(rdy), 1);
    check_eq("rst_strobes", int'({s_wren, ct_wren}), 0);
    check_eq("rst_addrs", int'({s_addr, pt_addr, ct_addr}), 0);
    check_eq("rst_wdata", int'({s_wrdata, ct_wrdata}), 0);
`ifdef ARC4_ENC_CHECKSUM_EN
    check_eq("rst_chk", int'(chk), 0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // Identity S, PT = {02,41,42}
    model_identity();
    load_mems();
    pt_mem[0] = 8'h02; pt_mem[1] = 8'h41; pt_mem[2] = 8'h42;
    run_enc(1'b0, cyc);
    check_eq("id_latency", cyc, 15);
    check_eq("id_ct0", int'(ct_mem[0]), 8'h02);
    check_eq("id_ct1", int'(ct_mem[1]), 8'h43);
    check_eq("id_ct2", int'(ct_mem[2]), 8'h47);
    check_eq("id_s2", int'(s_mem[2]), 8'h03);
    check_eq("id_s3", int'(s_mem[3]), 8'h02);
    check_eq("id_ct3_untouched", int'(ct_mem[3]), 8'hEE);
`ifdef ARC4_ENC_CHECKSUM_EN
    check_eq("id_chk", int'(chk), 8'h06);
`endif

    // Zero-length message
    model_identity();
    load_mems();
    pt_mem[0] = 8'h00;
    run_enc(1'b0, cyc);
    check_eq("len0_latency", cyc, 3);
    check_eq("len0_ct0", int'(ct_mem[0]), 0);
    check_eq("len0_ct1_untouched", int'(ct_mem[1]), 8'hEE);
    check_eq("len0_s_writes", s_wr_cnt, 0);
    check_eq("len0_ct_writes", ct_wr_cnt, 1);

    // Random permutations, random lengths
    for (int t = 0; t < 4; t++) begin
      len = $urandom_range(1, 40);
      model_shuffle();
      load_mems();
      fill_pt(len);
      run_enc(1'b0, cyc);
      check_eq("rand_latency", cyc, 3 + 6 * len);
      check_vs_model("rand", len);
    end

    // Key 00033C, 255-byte message, decrypt round trip
    model_ksa(8'h00, 8'h03, 8'h3C);
    load_mems();
    fill_pt(255);
    run_enc(1'b0, cyc);
    check_eq("max_latency", cyc, 1533);
    check_eq("max_ct0", int'(ct_mem[0]), 255);
    begin
      int bad;
      model_ksa(8'h00, 8'h03, 8'h3C);
      for (int n = 0; n < 256; n++) m_in[n] = ct_mem[n];
      model_prga(255);
      bad = 0;
      for (int n = 1; n <= 255; n++) if (m_out[n] !== pt_mem[n]) bad++;
      check_eq("max_roundtrip_bad", bad, 0);
    end

    // en pulsed while busy
    len = 12;
    model_shuffle();
    load_mems();
    fill_pt(len);
    run_enc(1'b1, cyc);
    check_eq("pulse_latency", cyc, 3 + 6 * len);
    check_vs_model("pulse", len);

    // Async reset during byte 5, then a clean rerun
    len = 20;
    model_shuffle();
    load_mems();
    fill_pt(len);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (31) @(posedge clk);
    #1 check_eq("midrst_pre_ct_wren", int'(ct_wren), 1);
    check_eq("midrst_pre_ct_addr", int'(ct_addr), 5);
    #2 rst_n = 1'b0;
    #1 check_eq("midrst_rdy", int'(rdy), 1);
    check_eq("midrst_strobes", int'({s_wren, ct_wren}), 0);
    check_eq("midrst_addrs", int'({s_addr, pt_addr, ct_addr}), 0);
    @(negedge clk) rst_n = 1'b1;
    load_mems();
    run_enc(1'b0, cyc);
    check_eq("midrst_latency", cyc, 3 + 6 * len);
    check_vs_model("midrst", len);

    check_eq("strobe_exclusive", excl_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
